bcd_conv_sched: RTL and testbench
=================================

// Module: bcd_conv_sched
// PURPOSE
// - Shares a single 16-bit binary-to-BCD converter (bin2bcd) among NREQ requesters (operand A, operand B, result, ...).
// - Grants requesters round-robin and holds the converter input stable for the converter's settle time.
// - Captures the 20-bit BCD result and returns it, tagged with the requester id, to the display/formatting logic.
// PARAMETERS
// - NREQ      default 3   number of requesters, 2..8
// - CONV_LAT  default 6   cycles the converter needs with data_i held stable before data_o is valid; must be >= 6
// - IDW       default 3   width of requester id, >= clog2(NREQ)
// PORTS
// - sclk        in   1         system clock, all logic on posedge
// - rst_n       in   1         reset, asynchronous, active-high (asserted = 1)
// - req_valid   in   NREQ      per-requester request strobe, held until accepted
// - req_data    in   16*NREQ   per-requester binary value; slice i = [16*i+15:16*i]
// - req_ready   out  NREQ      one-hot accept, 1 cycle, in the cycle the request is taken
// - conv_din    out  16        to converter data_i; held constant during a conversion
// - conv_dout   in   20        from converter data_o, 5 BCD digits
// - rsp_valid   out  1         BCD result available
// - rsp_id      out  IDW       requester id of the result
// - rsp_bcd     out  20        BCD result, digit 4 in [19:16]
// - rsp_ready   in   1         consumer accepts the result when rsp_valid && rsp_ready
// - busy        out  1         high in every state except IDLE
// BEHAVIOUR
// - Reset (async, rst_n=1): state=IDLE, rr_ptr=0, conv_din=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_bcd=0, busy=0.
// - FSM IDLE -> GRANT -> SETTLE -> RESP -> IDLE.
// - IDLE: if any req_valid, pick the first asserted index searching from rr_ptr upward and wrapping; go to GRANT.
// - GRANT (1 cycle):
//   - req_ready[g]=1 for granted g only; latch conv_din=req_data[g] and id=g.
//   - rr_ptr=(g+1) mod NREQ; cnt=0.
// - SETTLE: cnt increments each cycle; conv_din is not modified.
//   - When cnt==CONV_LAT-1, register rsp_bcd=conv_dout and rsp_id=id, set rsp_valid=1; go to RESP.
//   - The first valid response appears CONV_LAT+1 cycles after GRANT.
// - RESP: hold rsp_valid, rsp_id and rsp_bcd stable until rsp_ready.
//   - On the accepting cycle, clear rsp_valid and go to IDLE.
//   - No new grant is issued in that same cycle, so the minimum spacing between grants is CONV_LAT+3 cycles.
// - Handshake rules:
//   - req_valid dropping before its grant is legal; that request is skipped.
//   - req_data must be stable only in the GRANT cycle.
//   - rsp_ready may be tied high.
// - Arbitration:
//   - Strict round-robin; a requester that keeps req_valid high waits at most NREQ-1 conversions.
//   - Simultaneous requests resolve from rr_ptr; rr_ptr wraps NREQ-1 -> 0.
// - Widths: conv_din is 16 b; max input 0xFFFF gives BCD 0x65535, which fits 20 b with no overflow flag.
//   - cnt is clog2(CONV_LAT)+1 bits and saturates at CONV_LAT-1.
// - Reset mid-conversion abandons the conversion: no rsp_valid, and rr_ptr returns to 0.
// - An out-of-range index (NREQ < 2^IDW) is never granted.
// STRUCTURE
// - Shared package calc_pkg:
//   - state enum (IDLE/GRANT/SETTLE/RESP)
//   - BCD_W=20, BIN_W=16
//   - default CONV_LAT=6 (converter latency constant)
// - Sub-module rr_arbiter: NREQ request vector plus pointer in, one-hot grant plus index out; purely combinational.
// - The bin2bcd converter is instantiated by the parent, not inside this block.
// TESTING
// - Bench instantiates bcd_conv_sched together with a real bin2bcd; both get the same sclk and rst_n.
// - Single request:
//   - Stimulus: req_valid[0]=1 with 16'h04D2, rsp_ready=1.
//   - Response: req_ready[0] pulses 1 cycle; rsp_valid 7 cycles after GRANT with rsp_bcd=20'h01234, rsp_id=0.
// - Boundary values:
//   - 16'hFFFF -> rsp_bcd 20'h65535.
//   - 16'h0000 -> 20'h00000.
//   - 16'd9999 -> 20'h09999.
//   - 16'd10000 -> 20'h10000.
// - Round-robin:
//   - Stimulus: all 3 req_valid held high with values 1, 22, 333.
//   - Response: grants in order 0, 1, 2, 0; responses 20'h00001, 20'h00022, 20'h00333 with matching ids.
// - Backpressure:
//   - Stimulus: rsp_ready=0 for 20 cycles.
//   - Response: rsp_valid, rsp_id and rsp_bcd stay constant; no req_ready asserts; state stays RESP; accept on the first cycle rsp_ready=1.
// - Input stability:
//   - Stimulus: change req_data[1] every cycle after its grant.
//   - Response: conv_din is unchanged through SETTLE; result matches the value sampled at GRANT.
// - Reset in SETTLE:
//   - Stimulus: assert rst_n=1 asynchronously in the middle of a conversion.
//   - Response: all outputs reach their reset values immediately; no rsp_valid after release; the next grant comes from index 0.

Source files
------------

// File: rtl/bcd_conv_sched_pkg.sv
// rtl/bcd_conv_sched_pkg.sv - shared types, widths and BCD helper for the converter scheduler
package bcd_conv_sched_pkg;

  localparam int BIN_W        = 16;
  localparam int BCD_W        = 20;
  localparam int DEF_CONV_LAT = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_SETTLE,
    ST_RESP
  } state_t;

  // Shift-and-add-3: five digits cover the full 16-bit range (max 65535)
  function automatic logic [BCD_W-1:0] bin_to_bcd(input logic [BIN_W-1:0] bin);
    logic [BCD_W+BIN_W-1:0] sh;
    sh = {{BCD_W{1'b0}}, bin};
    for (int i = 0; i < BIN_W; i++) begin
      for (int d = 0; d < BCD_W / 4; d++) begin
        if (sh[BIN_W+4*d +: 4] >= 4'd5) begin
          sh[BIN_W+4*d +: 4] = sh[BIN_W+4*d +: 4] + 4'd3;
        end
      end
      sh = sh << 1;
    end
    return sh[BIN_W +: BCD_W];
  endfunction

endpackage

// File: rtl/bcd_conv_sched_if.sv
// rtl/bcd_conv_sched_if.sv - requester and response handshake bundle of the converter scheduler
interface bcd_conv_sched_if
  import bcd_conv_sched_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int IDW  = 3
);

  logic [NREQ-1:0]       req_valid;
  logic [BIN_W*NREQ-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic [IDW-1:0]        rsp_id;
  logic [BCD_W-1:0]      rsp_bcd;
  logic                  rsp_ready;

  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_bcd
  );

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_bcd
  );

endinterface

// File: rtl/bcd_conv_sched_rr_arbiter.sv
// rtl/bcd_conv_sched_rr_arbiter.sv - combinational round-robin pick starting at a pointer
module rr_arbiter #(
  parameter int NREQ = 3,
  parameter int IDW  = 3
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  int p;
  int k;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    p   = int'(ptr);
    k   = 0;
    // Pointer values past NREQ-1 cannot occur, but are folded to 0 defensively
    if (p >= NREQ) begin
      p = 0;
    end
    for (int off = 0; off < NREQ; off++) begin
      k = p + off;
      if (k >= NREQ) begin
        k = k - NREQ;
      end
      if (!any && req[k]) begin
        any    = 1'b1;
        gnt[k] = 1'b1;
        idx    = IDW'(k);
      end
    end
  end

endmodule

// File: rtl/bin2bcd.sv
// rtl/bin2bcd.sv - registered 16-bit binary to 5-digit BCD converter shared by the scheduler
module bin2bcd
  import bcd_conv_sched_pkg::*;
(
  input  logic             sclk,
  input  logic             rst_n,
  input  logic [BIN_W-1:0] data_i,
  output logic [BCD_W-1:0] data_o
);

  always_ff @(posedge sclk or posedge rst_n) begin
    if (rst_n) begin
      data_o <= '0;
    end else begin
      data_o <= bin_to_bcd(data_i);
    end
  end

endmodule

// File: rtl/bcd_conv_sched.sv
// rtl/bcd_conv_sched.sv - round-robin scheduler sharing one external bin2bcd among NREQ requesters
module bcd_conv_sched
  import bcd_conv_sched_pkg::*;
#(
  parameter int NREQ     = 3,
  parameter int CONV_LAT = DEF_CONV_LAT,
  parameter int IDW      = 3
) (
  input  logic             sclk,
  input  logic             rst_n,
  bcd_conv_sched_if.slave  bus,
  output logic [BIN_W-1:0] conv_din,
  input  logic [BCD_W-1:0] conv_dout,
  output logic             busy
);

  localparam int CW = $clog2(CONV_LAT) + 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(CONV_LAT - 1);
  localparam logic [IDW-1:0] ID_LAST  = IDW'(NREQ - 1);

  state_t          state;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  gidx;
  logic [CW-1:0]   cnt;

  logic [NREQ-1:0] arb_gnt;
  logic [IDW-1:0]  arb_idx;
  logic            arb_any;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req (bus.req_valid),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  always_ff @(posedge sclk or posedge rst_n) begin
    if (rst_n) begin
      state         <= ST_IDLE;
      rr_ptr        <= '0;
      gidx          <= '0;
      cnt           <= '0;
      conv_din      <= '0;
      busy          <= 1'b0;
      bus.req_ready <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_bcd   <= '0;
    end else begin
      bus.req_ready <= '0;
      case (state)
        ST_IDLE: begin
          if (arb_any) begin
            state         <= ST_GRANT;
            gidx          <= arb_idx;
            bus.req_ready <= arb_gnt;
            busy          <= 1'b1;
          end
        end
        ST_GRANT: begin
          // Data is sampled at the end of the accept cycle, so requesters need only hold it then
          conv_din <= bus.req_data[int'(gidx)*BIN_W +: BIN_W];
          rr_ptr   <= (gidx == ID_LAST) ? '0 : gidx + 1'b1;
          cnt      <= '0;
          state    <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt == CNT_LAST) begin
            bus.rsp_bcd   <= conv_dout;
            bus.rsp_id    <= gidx;
            bus.rsp_valid <= 1'b1;
            state         <= ST_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            busy          <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_conv_sched.sv
// tb/tb_bcd_conv_sched.sv - directed scoreboard bench for bcd_conv_sched with a real bin2bcd
module tb_bcd_conv_sched;
  import bcd_conv_sched_pkg::*;

  localparam int LAT = 6;

  typedef struct {
    logic [2:0]  id;
    logic [19:0] bcd;
  } exp_t;

  logic        sclk;
  logic        rst_n;
  logic [15:0] conv_din;
  logic [19:0] conv_dout;
  logic        busy;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   rsp_cyc;
  int   g_cyc;
  exp_t sb[$];

  logic [2:0] rr_exp[4];
  int         rr_val[3];

  bcd_conv_sched_if #(.NREQ(3), .IDW(3)) bus ();

  bcd_conv_sched #(
    .NREQ     (3),
    .CONV_LAT (LAT),
    .IDW      (3)
  ) dut (
    .sclk      (sclk),
    .rst_n     (rst_n),
    .bus       (bus),
    .conv_din  (conv_din),
    .conv_dout (conv_dout),
    .busy      (busy)
  );

  bin2bcd u_conv (
    .sclk   (sclk),
    .rst_n  (rst_n),
    .data_i (conv_din),
    .data_o (conv_dout)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;
  always @(posedge sclk) cyc <= cyc + 1;

  function automatic logic [19:0] ref_bcd(input int v);
    return {4'(v / 10000), 4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_grant(input string tag, input logic [2:0] exp_gnt);
    int n = 0;
    while (bus.req_ready === 3'b000 && n < 40) begin
      @(negedge sclk);
      n++;
    end
    g_cyc = cyc;
    chk(tag, 32'(bus.req_ready), 32'(exp_gnt));
  endtask

  task automatic wait_rsp(input string tag);
    exp_t e;
    int   n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 60) begin
      @(negedge sclk);
      n++;
    end
    rsp_cyc = cyc;
    chk({tag, "_v"}, 32'(bus.rsp_valid), 32'd1);
    if (sb.size() == 0) begin
      chk({tag, "_sb"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_id"}, 32'(bus.rsp_id), 32'(e.id));
      chk({tag, "_bcd"}, 32'(bus.rsp_bcd), 32'(e.bcd));
    end
  endtask

  task automatic do_single(input int idx, input logic [15:0] val, input string tag);
    bus.req_data[idx*16 +: 16] = val;
    bus.req_valid[idx] = 1'b1;
    wait_grant({tag, "_gnt"}, 3'(1 << idx));
    sb.push_back('{3'(idx), ref_bcd(int'(val))});
    bus.req_valid[idx] = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    @(negedge sclk);
    chk({tag, "_rdy_pulse"}, 32'(bus.req_ready), 32'd0);
    wait_rsp(tag);
    chk({tag, "_lat"}, 32'(rsp_cyc - g_cyc), 32'(LAT + 1));
    @(negedge sclk);
    chk({tag, "_acc"}, 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b1;
    #1 rst_n = 1'b1;
    @(negedge sclk);
    @(negedge sclk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    chk("rst_rsp_bcd", 32'(bus.rsp_bcd), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_conv_din", 32'(conv_din), 32'd0);
    rst_n = 1'b0;
    @(negedge sclk);

    // Single request, then boundary values arranged so rr_ptr ends back at 0
    do_single(0, 16'h04D2, "single");
    do_single(1, 16'hFFFF, "b_ffff");
    do_single(2, 16'h0000, "b_0000");
    do_single(1, 16'd9999, "b_9999");
    do_single(2, 16'd10000, "b_10000");

    // Round-robin with all three held high
    rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001};
    rr_val = '{1, 22, 333};
    for (int i = 0; i < 3; i++) bus.req_data[i*16 +: 16] = 16'(rr_val[i]);
    bus.req_valid = 3'b111;
    for (int i = 0; i < 4; i++) begin
      int prev_g;
      prev_g = g_cyc;
      wait_grant("rr_gnt", rr_exp[i]);
      if (i > 0) chk("rr_spacing", 32'(g_cyc - prev_g), 32'(LAT + 3));
      sb.push_back('{3'(i % 3), ref_bcd(rr_val[i % 3])});
      if (i == 3) bus.req_valid = 3'b000;
      wait_rsp("rr");
      @(negedge sclk);
    end

    // Backpressure: response held 20 cycles while requester 2 waits
    bus.rsp_ready = 1'b0;
    bus.req_data[31:16] = 16'd4321;
    bus.req_data[47:32] = 16'd8765;
    bus.req_valid = 3'b110;
    wait_grant("bp_gnt", 3'b010);
    sb.push_back('{3'd1, ref_bcd(4321)});
    bus.req_valid[1] = 1'b0;
    wait_rsp("bp");
    for (int k = 0; k < 20; k++) begin
      @(negedge sclk);
      chk("bp_hold_v", 32'(bus.rsp_valid), 32'd1);
      chk("bp_hold_id", 32'(bus.rsp_id), 32'd1);
      chk("bp_hold_bcd", 32'(bus.rsp_bcd), 32'(ref_bcd(4321)));
      chk("bp_no_rdy", 32'(bus.req_ready), 32'd0);
      chk("bp_state", 32'(dut.state), 32'(ST_RESP));
    end
    bus.rsp_ready = 1'b1;
    @(negedge sclk);
    chk("bp_acc", 32'(bus.rsp_valid), 32'd0);
    wait_grant("bp_next_gnt", 3'b100);
    sb.push_back('{3'd2, ref_bcd(8765)});
    bus.req_valid[2] = 1'b0;
    wait_rsp("bp_next");
    @(negedge sclk);

    // Input stability: req_data[1] scrambled every cycle after its grant
    bus.req_data[31:16] = 16'd4660;
    bus.req_valid[1] = 1'b1;
    wait_grant("stab_gnt", 3'b010);
    sb.push_back('{3'd1, ref_bcd(4660)});
    bus.req_valid[1] = 1'b0;
    for (int k = 0; k < LAT; k++) begin
      @(negedge sclk);
      bus.req_data[31:16] = 16'($urandom);
      chk("stab_din", 32'(conv_din), 32'd4660);
    end
    wait_rsp("stab");
    @(negedge sclk);

    // Asynchronous reset in the middle of SETTLE
    bus.req_data[31:16] = 16'd777;
    bus.req_valid[1] = 1'b1;
    wait_grant("rst_mid_gnt", 3'b010);
    bus.req_valid[1] = 1'b0;
    repeat (3) @(negedge sclk);
    #2 rst_n = 1'b1;
    #1;
    chk("rm_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rm_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rm_rsp_id", 32'(bus.rsp_id), 32'd0);
    chk("rm_rsp_bcd", 32'(bus.rsp_bcd), 32'd0);
    chk("rm_busy", 32'(busy), 32'd0);
    chk("rm_conv_din", 32'(conv_din), 32'd0);
    @(negedge sclk);
    rst_n = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge sclk);
      chk("rm_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    bus.req_data[15:0]  = 16'd50;
    bus.req_data[31:16] = 16'd51;
    bus.req_data[47:32] = 16'd52;
    bus.req_valid = 3'b111;
    wait_grant("rm_next_gnt", 3'b001);
    sb.push_back('{3'd0, ref_bcd(50)});
    bus.req_valid = 3'b000;
    wait_rsp("rm_next");
    @(negedge sclk);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
